// File: rtl/ep2_alu_pipe.sv
// ep2_alu_pipe: joins the lval/rval operand streams, computes one ALU result per pair and
// delivers it through a PIPE_STAGES-deep elastic pipeline with a delivered-result counter.
module ep2_alu_pipe #(
  parameter int LVAL_SIZE   = 16,
  parameter int RVAL_SIZE   = 16,
  parameter int RESULT_SIZE = 32,
  parameter int OPID        = 0,
  parameter int DYNAMIC_OP  = 0,
  parameter int SIGNED      = 0,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LVAL_SIZE-1:0]   s_lval_axis_tdata,
  input  logic [3:0]             s_lval_axis_tuser,
  input  logic                   s_lval_axis_tvalid,
  output logic                   s_lval_axis_tready,
  input  logic [RVAL_SIZE-1:0]   s_rval_axis_tdata,
  input  logic                   s_rval_axis_tvalid,
  output logic                   s_rval_axis_tready,
  output logic [RESULT_SIZE-1:0] m_val_axis_tdata,
  output logic [1:0]             m_val_axis_tuser,
  output logic                   m_val_axis_tvalid,
  input  logic                   m_val_axis_tready,
  output logic [31:0]            stat_count
);

  localparam int MAX_LR = (LVAL_SIZE > RVAL_SIZE) ? LVAL_SIZE : RVAL_SIZE;
  localparam int W      = ((MAX_LR > RESULT_SIZE) ? MAX_LR : RESULT_SIZE) + 1;

  typedef enum logic [3:0] {
    OP_SUB  = 4'd0,  OP_ADD = 4'd1,  OP_LAND = 4'd2,  OP_LT  = 4'd3,
    OP_GT   = 4'd4,  OP_EQ  = 4'd5,  OP_LE   = 4'd6,  OP_GE  = 4'd7,
    OP_OR   = 4'd8,  OP_XOR = 4'd9,  OP_BAND = 4'd10, OP_SHL = 4'd11,
    OP_SHR  = 4'd12
  } op_e;

  op_e                   op;
  logic [W-1:0]          opa, opb, sum, diff, shl_v, shr_v, res_w;
  logic [63:0]           shamt;
  logic                  sh_big, lt, gt, eq, add_flag, sub_flag;
  logic [1:0]            res_user;
  logic                  join_ready, fire, chain;

  logic [PIPE_STAGES-1:0] stg_valid, stg_ready, in_valid;
  logic [RESULT_SIZE-1:0] stg_data [PIPE_STAGES];
  logic [RESULT_SIZE-1:0] in_data  [PIPE_STAGES];
  logic [1:0]             stg_user [PIPE_STAGES];
  logic [1:0]             in_user  [PIPE_STAGES];

  assign op = op_e'((DYNAMIC_OP != 0) ? s_lval_axis_tuser : 4'(OPID));

  always_comb begin
    if (SIGNED != 0) begin
      opa = {{(W-LVAL_SIZE){s_lval_axis_tdata[LVAL_SIZE-1]}}, s_lval_axis_tdata};
      opb = {{(W-RVAL_SIZE){s_rval_axis_tdata[RVAL_SIZE-1]}}, s_rval_axis_tdata};
      lt  = $signed(opa) < $signed(opb);
      gt  = $signed(opa) > $signed(opb);
    end else begin
      opa = {{(W-LVAL_SIZE){1'b0}}, s_lval_axis_tdata};
      opb = {{(W-RVAL_SIZE){1'b0}}, s_rval_axis_tdata};
      lt  = opa < opb;
      gt  = opa > opb;
    end
  end

  assign eq    = (opa == opb);
  assign sum   = opa + opb;
  assign diff  = opa - opb;
  // Shift amount is rval taken as unsigned; anything >= RESULT_SIZE saturates.
  assign shamt  = 64'(s_rval_axis_tdata);
  assign sh_big = (shamt >= 64'(RESULT_SIZE));
  assign shl_v  = opa << shamt[6:0];

  always_comb begin
    if (SIGNED != 0) begin
      shr_v    = $signed(opa) >>> shamt[6:0];
      add_flag = (sum[W-1:RESULT_SIZE-1] != '0) && (sum[W-1:RESULT_SIZE-1] != '1);
      sub_flag = (diff[W-1:RESULT_SIZE-1] != '0) && (diff[W-1:RESULT_SIZE-1] != '1);
    end else begin
      shr_v    = opa >> shamt[6:0];
      add_flag = |sum[W-1:RESULT_SIZE];
      sub_flag = |diff[W-1:RESULT_SIZE];
    end
  end

  always_comb begin
    res_w    = '0;
    res_user = 2'b00;
    case (op)
      OP_SUB:  begin res_w = diff; res_user[0] = sub_flag; end
      OP_ADD:  begin res_w = sum;  res_user[0] = add_flag; end
      OP_LAND: res_w = W'((|s_lval_axis_tdata) && (|s_rval_axis_tdata));
      OP_LT:   res_w = W'(lt);
      OP_GT:   res_w = W'(gt);
      OP_EQ:   res_w = W'(eq);
      OP_LE:   res_w = W'(!gt);
      OP_GE:   res_w = W'(!lt);
      OP_OR:   res_w = opa | opb;
      OP_XOR:  res_w = opa ^ opb;
      OP_BAND: res_w = opa & opb;
      OP_SHL:  res_w = sh_big ? '0 : shl_v;
      OP_SHR: begin
        if (!sh_big)                     res_w = shr_v;
        else if (SIGNED != 0 && opa[W-1]) res_w = '1;
        else                             res_w = '0;
      end
      default: res_user[1] = 1'b1;
    endcase
  end

  // Ready ripples back from the output: a stage accepts when empty or when its successor does.
  always_comb begin
    stg_ready = '0;
    chain     = m_val_axis_tready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      chain        = chain | ~stg_valid[i];
      stg_ready[i] = chain;
    end
  end

  assign join_ready         = stg_ready[0] & rst;
  assign s_lval_axis_tready = s_rval_axis_tvalid & join_ready;
  assign s_rval_axis_tready = s_lval_axis_tvalid & join_ready;
  assign fire               = s_lval_axis_tvalid & s_rval_axis_tvalid & join_ready;

  always_comb begin
    in_valid    = '0;
    in_valid[0] = fire;
    in_data[0]  = res_w[RESULT_SIZE-1:0];
    in_user[0]  = res_user;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      in_valid[i] = stg_valid[i-1];
      in_data[i]  = stg_data[i-1];
      in_user[i]  = stg_user[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        stg_data[i] <= '0;
        stg_user[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (stg_ready[i]) begin
          stg_valid[i] <= in_valid[i];
          if (in_valid[i]) begin
            stg_data[i] <= in_data[i];
            stg_user[i] <= in_user[i];
          end
        end
      end
    end
  end

  assign m_val_axis_tvalid = stg_valid[PIPE_STAGES-1];
  assign m_val_axis_tdata  = stg_data[PIPE_STAGES-1];
  assign m_val_axis_tuser  = stg_user[PIPE_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stat_count <= '0;
    else if (m_val_axis_tvalid && m_val_axis_tready)
      stat_count <= stat_count + 32'd1;
  end

endmodule

// File: tb/tb_ep2_alu_pipe.sv
// tb_ep2_alu_pipe: three ep2_alu_pipe configurations share one stimulus stream and are checked
// in lockstep against hand-computed vectors (static ADD 16/16/32, signed dynamic, 16-bit result).
module tb_ep2_alu_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] lval_data;
  logic [3:0]  lval_user;
  logic        lval_valid;
  logic [15:0] rval_data;
  logic        rval_valid;
  logic        m_ready;

  logic        a_lready, a_rready, a_valid;
  logic [31:0] a_data, a_stat;
  logic [1:0]  a_user;
  logic        b_lready, b_rready, b_valid;
  logic [31:0] b_data, b_stat;
  logic [1:0]  b_user;
  logic        c_lready, c_rready, c_valid;
  logic [15:0] c_data;
  logic [31:0] c_stat;
  logic [1:0]  c_user;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  op;
    logic [31:0] ad;
    logic [1:0]  au;
    logic [31:0] bd;
    logic [1:0]  bu;
    logic [15:0] cd;
    logic [1:0]  cu;
  } vec_t;

  vec_t vecs [16];

  ep2_alu_pipe #(.OPID(1), .DYNAMIC_OP(0), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst),
    .s_lval_axis_tdata(lval_data), .s_lval_axis_tuser(lval_user),
    .s_lval_axis_tvalid(lval_valid), .s_lval_axis_tready(a_lready),
    .s_rval_axis_tdata(rval_data), .s_rval_axis_tvalid(rval_valid),
    .s_rval_axis_tready(a_rready),
    .m_val_axis_tdata(a_data), .m_val_axis_tuser(a_user),
    .m_val_axis_tvalid(a_valid), .m_val_axis_tready(m_ready),
    .stat_count(a_stat)
  );

  ep2_alu_pipe #(.DYNAMIC_OP(1), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst),
    .s_lval_axis_tdata(lval_data), .s_lval_axis_tuser(lval_user),
    .s_lval_axis_tvalid(lval_valid), .s_lval_axis_tready(b_lready),
    .s_rval_axis_tdata(rval_data), .s_rval_axis_tvalid(rval_valid),
    .s_rval_axis_tready(b_rready),
    .m_val_axis_tdata(b_data), .m_val_axis_tuser(b_user),
    .m_val_axis_tvalid(b_valid), .m_val_axis_tready(m_ready),
    .stat_count(b_stat)
  );

  ep2_alu_pipe #(.RESULT_SIZE(16), .DYNAMIC_OP(1), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst),
    .s_lval_axis_tdata(lval_data), .s_lval_axis_tuser(lval_user),
    .s_lval_axis_tvalid(lval_valid), .s_lval_axis_tready(c_lready),
    .s_rval_axis_tdata(rval_data), .s_rval_axis_tvalid(rval_valid),
    .s_rval_axis_tready(c_rready),
    .m_val_axis_tdata(c_data), .m_val_axis_tuser(c_user),
    .m_val_axis_tvalid(c_valid), .m_val_axis_tready(m_ready),
    .stat_count(c_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    lval_valid = 1'b0;
    rval_valid = 1'b0;
  endtask

  task automatic drive_vec(input int idx);
    lval_data  = vecs[idx].l;
    lval_user  = vecs[idx].op;
    rval_data  = vecs[idx].r;
    lval_valid = 1'b1;
    rval_valid = 1'b1;
  endtask

  // Streams vecs[first +: n]; output checked each cycle against the expected head beat.
  task automatic run_stream(input int first, input int n, input bit toggle,
                            output int cycles, output int first_out);
    int in_idx, out_idx, cyc;
    bit in_fire;
    in_idx = 0; out_idx = 0; cyc = 0; first_out = -1;
    drive_vec(first);
    m_ready = 1'b1;
    while (out_idx < n && cyc < 300) begin
      @(negedge clk);
      in_fire = lval_valid && a_lready && rval_valid && a_rready;
      if (a_valid) begin
        if (first_out < 0) first_out = cyc;
        chk("a_data", a_data, vecs[first+out_idx].ad);
        if (m_ready) begin
          chk("a_user", a_user, vecs[first+out_idx].au);
          chk("b_data", b_data, vecs[first+out_idx].bd);
          chk("b_user", b_user, vecs[first+out_idx].bu);
          chk("c_data", c_data, vecs[first+out_idx].cd);
          chk("c_user", c_user, vecs[first+out_idx].cu);
          out_idx++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (in_fire) in_idx++;
      if (in_idx < n) drive_vec(first + in_idx);
      else idle();
      m_ready = toggle ? (cyc % 3 == 0) : 1'b1;
    end
    idle();
    m_ready = 1'b1;
    chk("stream_count", out_idx, n);
    cycles = cyc;
  endtask

  initial begin
    int cyc, fo, cnt;
    //           l        r        op     a data        au    b data        bu    c data    cu
    vecs[0]  = '{16'hFFFF, 16'h0001, 4'd1,  32'h0001_0000, 2'd0, 32'h0000_0000, 2'd0, 16'h0000, 2'd1};
    vecs[1]  = '{16'h0000, 16'h0001, 4'd0,  32'h0000_0001, 2'd0, 32'hFFFF_FFFF, 2'd0, 16'hFFFF, 2'd1};
    vecs[2]  = '{16'hFFFE, 16'h0001, 4'd3,  32'h0000_FFFF, 2'd0, 32'h0000_0001, 2'd0, 16'h0000, 2'd0};
    vecs[3]  = '{16'h8000, 16'h0014, 4'd12, 32'h0000_8014, 2'd0, 32'hFFFF_FFFF, 2'd0, 16'h0000, 2'd0};
    vecs[4]  = '{16'h1234, 16'h0000, 4'd14, 32'h0000_1234, 2'd0, 32'h0000_0000, 2'd2, 16'h0000, 2'd2};
    vecs[5]  = '{16'h00F0, 16'h0004, 4'd11, 32'h0000_00F4, 2'd0, 32'h0000_0F00, 2'd0, 16'h0F00, 2'd0};
    vecs[6]  = '{16'h00FF, 16'h0F0F, 4'd9,  32'h0000_100E, 2'd0, 32'h0000_0FF0, 2'd0, 16'h0FF0, 2'd0};
    vecs[7]  = '{16'h0005, 16'h0005, 4'd5,  32'h0000_000A, 2'd0, 32'h0000_0001, 2'd0, 16'h0001, 2'd0};
    vecs[8]  = '{16'h0003, 16'h0000, 4'd2,  32'h0000_0003, 2'd0, 32'h0000_0000, 2'd0, 16'h0000, 2'd0};
    vecs[9]  = '{16'h8000, 16'h0001, 4'd4,  32'h0000_8001, 2'd0, 32'h0000_0000, 2'd0, 16'h0001, 2'd0};
    vecs[10] = '{16'h7FFF, 16'h7FFF, 4'd1,  32'h0000_FFFE, 2'd0, 32'h0000_FFFE, 2'd0, 16'hFFFE, 2'd0};
    vecs[11] = '{16'h8000, 16'h8000, 4'd1,  32'h0001_0000, 2'd0, 32'hFFFF_0000, 2'd0, 16'h0000, 2'd1};
    vecs[12] = '{16'h0002, 16'h0002, 4'd7,  32'h0000_0004, 2'd0, 32'h0000_0001, 2'd0, 16'h0001, 2'd0};
    vecs[13] = '{16'h00FF, 16'h0F0F, 4'd10, 32'h0000_100E, 2'd0, 32'h0000_000F, 2'd0, 16'h000F, 2'd0};
    vecs[14] = '{16'h00F0, 16'h000F, 4'd8,  32'h0000_00FF, 2'd0, 32'h0000_00FF, 2'd0, 16'h00FF, 2'd0};
    vecs[15] = '{16'h0001, 16'hFFFF, 4'd6,  32'h0001_0000, 2'd0, 32'h0000_0000, 2'd0, 16'h0001, 2'd0};

    // Reset with both valids asserted: readies must stay low.
    rst = 1'b0; m_ready = 1'b1;
    lval_data = 16'h0; rval_data = 16'h0; lval_user = 4'd0;
    lval_valid = 1'b1; rval_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_lready", a_lready, 0);
    chk("rst_rready", a_rready, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_user", a_user, 0);
    chk("rst_stat", a_stat, 0);
    idle();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Lone lval must wait with nothing consumed.
    lval_data = 16'h0011; lval_user = 4'd1; rval_data = 16'h0022; lval_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("join_lone_lready", a_lready, 0);
      chk("join_lone_out", a_valid, 0);
      @(posedge clk); #1;
    end
    rval_valid = 1'b1;
    @(negedge clk);
    chk("join_lready", a_lready, 1);
    chk("join_rready", a_rready, 1);
    chk("join_b_lready", b_lready, 1);
    chk("join_c_rready", c_rready, 1);
    @(posedge clk); #1;
    idle();
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_valid) begin
        cnt++;
        chk("join_data", a_data, 32'h33);
      end
      @(posedge clk); #1;
    end
    chk("join_count", cnt, 1);
    chk("join_stat", a_stat, 1);

    // Full-rate stream of all vectors.
    run_stream(0, 16, 1'b0, cyc, fo);
    chk("stream_latency", fo, 2);
    chk("stream_cycles", cyc, 18);
    chk("stream_stat", a_stat, 17);

    @(negedge clk); rst = 1'b0;
    #2 chk("rst2_stat", a_stat, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Backpressure: output ready pattern 1,0,0 repeating.
    run_stream(0, 8, 1'b1, cyc, fo);
    chk("bp_latency", fo, 2);
    chk("bp_stat_a", a_stat, 8);
    chk("bp_stat_b", b_stat, 8);
    chk("bp_stat_c", c_stat, 8);

    // Two beats in flight, then asynchronous reset.
    m_ready = 1'b0;
    drive_vec(0);
    @(posedge clk); #1;
    drive_vec(1);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    @(negedge clk);
    chk("flight_valid", a_valid, 1);
    chk("flight_data", a_data, vecs[0].ad);
    drive_vec(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_data", a_data, 0);
    chk("arst_user", a_user, 0);
    chk("arst_stat", a_stat, 0);
    chk("arst_lready", a_lready, 0);
    chk("arst_b_valid", b_valid, 0);
    idle();
    m_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (a_valid) cnt++;
    end
    chk("post_rst_stale", cnt, 0);
    chk("post_rst_stat", a_stat, 0);
    @(posedge clk); #1;
    run_stream(2, 1, 1'b0, cyc, fo);
    chk("post_rst_stat1", a_stat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
